// File: rtl/multu_seq_ctl.sv
// multu_seq_ctl: multi-cycle radix-2 shift-add multiplier and HI/LO owner.
// Accepts mult/multu from EX and commits the 2*WIDTH-bit product to HI/LO
// after a fixed WIDTH+1 busy cycles. It stalls the pipeline on any HI/LO
// access, or a new start, while a multiply is in flight.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      multiply request (mult/multu)
//   is_signed  1 = mult (two's complement), 0 = multu
//   op_a/op_b  rs / rt operands
//   rd_hi/lo   EX holds mfhi / mflo
//   wr_hi/lo   EX holds mthi / mtlo, data on wr_data
//   busy       sequence in progress
//   stall      freeze IF/ID/EX while a HI/LO access collides with busy
//   done       one-cycle pulse after HI/LO commit
//   hi_out/lo_out  HI / LO registers
module multu_seq_ctl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             rd_hi,
    input  logic             rd_lo,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH:0]   acc;
    logic [CW-1:0]      counter;
    logic               neg;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] product;

    always_comb begin
        // Negating the most negative value yields the same bit pattern,
        // which read as unsigned is the correct magnitude.
        abs_a   = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
        abs_b   = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
        // Upper WIDTH+1 bits of acc hold the partial sum; the extra bit keeps the carry.
        sum     = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mcand} : '0);
        product = neg ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
        stall   = busy & (start | rd_hi | rd_lo | wr_hi | wr_lo);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            mcand   <= '0;
            acc     <= '0;
            counter <= '0;
            neg     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi_out  <= '0;
            lo_out  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_hi) hi_out <= wr_data;
                    if (wr_lo) lo_out <= wr_data;
                    if (start) begin
                        mcand   <= abs_a;
                        acc     <= {{(WIDTH+1){1'b0}}, abs_b};
                        neg     <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        counter <= '0;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    acc     <= {1'b0, sum, acc[WIDTH-1:1]};
                    counter <= counter + CW'(1);
                    if (counter == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    hi_out <= product[2*WIDTH-1:WIDTH];
                    lo_out <= product[WIDTH-1:0];
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multu_seq_ctl.sv
// Directed testbench for multu_seq_ctl (WIDTH=32).
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_multu_seq_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        rd_hi = 1'b0;
    logic        rd_lo = 1'b0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wr_data = '0;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int total = 0;
    int bad = 0;

    multu_seq_ctl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .op_a(op_a), .op_b(op_b), .rd_hi(rd_hi), .rd_lo(rd_lo),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
        .busy(busy), .stall(stall), .done(done),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance while busy (bounded). Reports busy cycles seen, busy cycles
    // without stall, and busy cycles where HI/LO moved from the entry value.
    task automatic run_busy(output int n, output int stall_miss, output int hold_miss);
        logic [31:0] h0, l0;
        h0 = hi_out;
        l0 = lo_out;
        n = 0;
        stall_miss = 0;
        hold_miss = 0;
        while (busy === 1'b1 && n < 60) begin
            if (stall !== 1'b1) stall_miss++;
            if (hi_out !== h0 || lo_out !== l0) hold_miss++;
            n++;
            tick();
        end
    endtask

    // Drive a request for one edge (E0) and drop start afterwards.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        is_signed = s;
        op_a = a;
        op_b = b;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({busy, done, hi_out, lo_out} !== 66'b0) begin
            bad++;
            $display("FAIL reset_init: busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi_out, lo_out);
        end
        tick();
        rst = 1'b1;
        tick();
        issue(1'b0, 32'd3, 32'd3);
        repeat (5) tick();
        #2 rst = 1'b0;
        #1;
        total++;
        if ({busy, done, hi_out, lo_out} !== 66'b0) begin
            bad++;
            $display("FAIL reset_mid_calc: busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi_out, lo_out);
        end
        tick();
        tick();
        rst = 1'b1;
        begin
            int done_seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (done === 1'b1 || busy === 1'b1) done_seen++;
                tick();
            end
            total++;
            if (done_seen != 0 || hi_out !== 32'h0 || lo_out !== 32'h0) begin
                bad++;
                $display("FAIL reset_no_commit: activity=%0d hi=%h lo=%h want 0/0/0", done_seen, hi_out, lo_out);
            end
        end
    endtask

    task automatic test_unsigned();
        int n, sm, hm;
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_busy(n, sm, hm);
        total++;
        if (n != 33) begin
            bad++;
            $display("FAIL unsigned_busy_len: got %0d want 33", n);
        end
        total++;
        if (hm != 0) begin
            bad++;
            $display("FAIL unsigned_hold: %0d busy cycles with HI/LO moved, want 0", hm);
        end
        total++;
        if (done !== 1'b1 || hi_out !== 32'hFFFF_FFFE || lo_out !== 32'h0000_0001) begin
            bad++;
            $display("FAIL unsigned_result: done=%b hi=%h lo=%h want 1 fffffffe 00000001", done, hi_out, lo_out);
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse_width: done=%b want 0", done);
        end
    endtask

    task automatic test_signed();
        int n, sm, hm;
        issue(1'b1, 32'd7, 32'hFFFF_FFFD);
        run_busy(n, sm, hm);
        total++;
        if (n != 33 || done !== 1'b1 || hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFEB) begin
            bad++;
            $display("FAIL signed_7xm3: n=%0d done=%b hi=%h lo=%h want 33 1 ffffffff ffffffeb", n, done, hi_out, lo_out);
        end
        tick();
        issue(1'b1, 32'h8000_0000, 32'h8000_0000);
        run_busy(n, sm, hm);
        total++;
        if (n != 33 || done !== 1'b1 || hi_out !== 32'h4000_0000 || lo_out !== 32'h0) begin
            bad++;
            $display("FAIL signed_minmin: n=%0d done=%b hi=%h lo=%h want 33 1 40000000 00000000", n, done, hi_out, lo_out);
        end
        tick();
    endtask

    task automatic test_hazard();
        int n, sm, hm;
        issue(1'b0, 32'h0001_0000, 32'h0000_0010);
        rd_lo = 1'b1;
        #0;
        run_busy(n, sm, hm);
        total++;
        if (n != 33 || sm != 0 || hm != 0) begin
            bad++;
            $display("FAIL hazard_stall: n=%0d nostall=%0d moved=%0d want 33 0 0", n, sm, hm);
        end
        total++;
        if (stall !== 1'b0 || done !== 1'b1 || lo_out !== 32'h0010_0000 || hi_out !== 32'h0) begin
            bad++;
            $display("FAIL hazard_done: stall=%b done=%b hi=%h lo=%h want 0 1 0 00100000", stall, done, hi_out, lo_out);
        end
        tick();
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL hazard_idle_read: stall=%b want 0", stall);
        end
        rd_lo = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n, sm, hm;
        issue(1'b0, 32'd2, 32'd2);
        run_busy(n, sm, hm);
        total++;
        if (done !== 1'b1 || lo_out !== 32'd4) begin
            bad++;
            $display("FAIL b2b_first: done=%b lo=%h want 1 00000004", done, lo_out);
        end
        start = 1'b1;
        op_a = 32'd3;
        op_b = 32'd5;
        #0;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done_stall: stall=%b want 0", stall);
        end
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept: busy=%b want 1", busy);
        end
        run_busy(n, sm, hm);
        total++;
        if (n != 33 || done !== 1'b1 || hi_out !== 32'h0 || lo_out !== 32'd15) begin
            bad++;
            $display("FAIL b2b_result: n=%0d done=%b hi=%h lo=%h want 33 1 0 0000000f", n, done, hi_out, lo_out);
        end
        tick();
        // Start raised mid-CALC must wait for IDLE.
        issue(1'b0, 32'd6, 32'd7);
        repeat (10) tick();
        start = 1'b1;
        op_a = 32'd9;
        op_b = 32'd9;
        #0;
        run_busy(n, sm, hm);
        total++;
        if (n != 23 || sm != 0 || done !== 1'b1 || lo_out !== 32'd42) begin
            bad++;
            $display("FAIL midcalc_start: n=%0d nostall=%0d done=%b lo=%h want 23 0 1 0000002a", n, sm, done, lo_out);
        end
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL midcalc_accept: busy=%b want 1", busy);
        end
        run_busy(n, sm, hm);
        total++;
        if (n != 33 || lo_out !== 32'd81) begin
            bad++;
            $display("FAIL midcalc_result: n=%0d lo=%h want 33 00000051", n, lo_out);
        end
        tick();
    endtask

    task automatic test_mthi_mtlo();
        int n, sm, hm;
        wr_hi = 1'b1;
        wr_data = 32'h1234_5678;
        tick();
        wr_hi = 1'b0;
        total++;
        if (hi_out !== 32'h1234_5678) begin
            bad++;
            $display("FAIL mthi_idle: hi=%h want 12345678", hi_out);
        end
        wr_lo = 1'b1;
        wr_data = 32'h0BAD_F00D;
        tick();
        wr_lo = 1'b0;
        total++;
        if (lo_out !== 32'h0BAD_F00D || hi_out !== 32'h1234_5678) begin
            bad++;
            $display("FAIL mtlo_idle: hi=%h lo=%h want 12345678 0badf00d", hi_out, lo_out);
        end
        // Write in the same cycle as start lands at E0, product overwrites at FIX.
        wr_hi = 1'b1;
        wr_data = 32'hAAAA_5555;
        issue(1'b0, 32'd2, 32'd3);
        wr_hi = 1'b0;
        total++;
        if (busy !== 1'b1 || hi_out !== 32'hAAAA_5555) begin
            bad++;
            $display("FAIL start_with_mthi: busy=%b hi=%h want 1 aaaa5555", busy, hi_out);
        end
        wr_lo = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        #0;
        run_busy(n, sm, hm);
        total++;
        if (n != 33 || sm != 0 || hm != 0) begin
            bad++;
            $display("FAIL mtlo_busy: n=%0d nostall=%0d moved=%0d want 33 0 0", n, sm, hm);
        end
        total++;
        if (done !== 1'b1 || stall !== 1'b0 || hi_out !== 32'h0 || lo_out !== 32'd6) begin
            bad++;
            $display("FAIL mtlo_busy_done: done=%b stall=%b hi=%h lo=%h want 1 0 0 00000006", done, stall, hi_out, lo_out);
        end
        tick();
        wr_lo = 1'b0;
        total++;
        if (lo_out !== 32'hDEAD_BEEF || hi_out !== 32'h0) begin
            bad++;
            $display("FAIL mtlo_after_idle: hi=%h lo=%h want 0 deadbeef", hi_out, lo_out);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_hazard();
        test_back_to_back();
        test_mthi_mtlo();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
